// File: rtl/db_engine.sv
// db_engine: hashed NUM_WAYS-way set-associative key/value table with ageing.
//   Resolves LOOKUP / INSERT / DELETE requests with a fixed 3-cycle latency.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       request handshake
//   in_op/in_key/in_value   request operation, key and insert value
//   out_valid/out_flag      one-cycle response strobe and response code
//   out_value               stored value on HIT, otherwise 0
//   ts_tick, cfg_timeout    timestamp advance and entry lifetime (0 = never expire)
//   hit_cnt, miss_cnt       saturating LOOKUP hit/miss counters
module db_engine #(
    parameter int unsigned KEY_SIZE  = 96,
    parameter int unsigned VAL_SIZE  = 32,
    parameter int unsigned FLAG_SIZE = 4,
    parameter int unsigned IDX_BITS  = 10,
    parameter int unsigned NUM_WAYS  = 2,
    parameter int unsigned TS_BITS   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLAG_SIZE-1:0] in_op,
    input  logic [KEY_SIZE-1:0]  in_key,
    input  logic [VAL_SIZE-1:0]  in_value,
    output logic                 out_valid,
    output logic [FLAG_SIZE-1:0] out_flag,
    output logic [VAL_SIZE-1:0]  out_value,
    input  logic                 ts_tick,
    input  logic [TS_BITS-1:0]   cfg_timeout,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
);

    localparam int unsigned BUCKETS  = 1 << IDX_BITS;
    localparam int unsigned NCHUNK   = (KEY_SIZE + IDX_BITS - 1) / IDX_BITS;
    localparam int unsigned WAY_BITS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    localparam logic [FLAG_SIZE-1:0] OP_LOOKUP = FLAG_SIZE'(1);
    localparam logic [FLAG_SIZE-1:0] OP_INSERT = FLAG_SIZE'(2);
    localparam logic [FLAG_SIZE-1:0] OP_DELETE = FLAG_SIZE'(3);

    localparam logic [FLAG_SIZE-1:0] RC_HIT      = FLAG_SIZE'(1);
    localparam logic [FLAG_SIZE-1:0] RC_MISS     = FLAG_SIZE'(2);
    localparam logic [FLAG_SIZE-1:0] RC_INSERTED = FLAG_SIZE'(3);
    localparam logic [FLAG_SIZE-1:0] RC_UPDATED  = FLAG_SIZE'(4);
    localparam logic [FLAG_SIZE-1:0] RC_FULL     = FLAG_SIZE'(5);
    localparam logic [FLAG_SIZE-1:0] RC_DELETED  = FLAG_SIZE'(6);
    localparam logic [FLAG_SIZE-1:0] RC_BADOP    = FLAG_SIZE'(7);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_RD, S_CMP, S_RESP} state_t;

    // XOR-fold of the key in IDX_BITS chunks, top chunk zero-padded.
    function automatic logic [IDX_BITS-1:0] hash_idx(input logic [KEY_SIZE-1:0] key);
        logic [NCHUNK*IDX_BITS-1:0] padded;
        logic [IDX_BITS-1:0]        acc;
        padded = '0;
        padded[KEY_SIZE-1:0] = key;
        acc = '0;
        for (int unsigned c = 0; c < NCHUNK; c++) begin
            acc = acc ^ padded[c*IDX_BITS +: IDX_BITS];
        end
        return acc;
    endfunction

    // Table storage (vld is cleared by the INIT sweep, not by reset)
    logic                vld_mem [NUM_WAYS][BUCKETS];
    logic [KEY_SIZE-1:0] key_mem [NUM_WAYS][BUCKETS];
    logic [VAL_SIZE-1:0] val_mem [NUM_WAYS][BUCKETS];
    logic [TS_BITS-1:0]  ts_mem  [NUM_WAYS][BUCKETS];

    // Bucket snapshot taken in RD
    logic                rd_vld [NUM_WAYS];
    logic [KEY_SIZE-1:0] rd_key [NUM_WAYS];
    logic [VAL_SIZE-1:0] rd_val [NUM_WAYS];
    logic [TS_BITS-1:0]  rd_ts  [NUM_WAYS];

    state_t               state;
    logic [IDX_BITS-1:0]  sweep_idx;
    logic [TS_BITS-1:0]   ts_now;
    logic [FLAG_SIZE-1:0] op_q;
    logic [KEY_SIZE-1:0]  key_q;
    logic [VAL_SIZE-1:0]  val_q;
    logic [IDX_BITS-1:0]  idx_q;

    logic                 wr_en;
    logic                 wr_vld;
    logic [WAY_BITS-1:0]  wr_way;
    logic [TS_BITS-1:0]   wr_ts;

    // Way resolution during CMP: first live match, first non-live way
    logic                 hit;
    logic [WAY_BITS-1:0]  hit_way;
    logic [VAL_SIZE-1:0]  hit_val;
    logic                 free;
    logic [WAY_BITS-1:0]  free_way;
    logic [TS_BITS-1:0]   age;
    logic                 live;

    always_comb begin
        hit      = 1'b0;
        hit_way  = '0;
        hit_val  = '0;
        free     = 1'b0;
        free_way = '0;
        age      = '0;
        live     = 1'b0;
        for (int unsigned w = 0; w < NUM_WAYS; w++) begin
            age  = ts_now - rd_ts[w];
            live = rd_vld[w] && ((cfg_timeout == '0) || (age < cfg_timeout));
            if (live && (rd_key[w] == key_q) && !hit) begin
                hit     = 1'b1;
                hit_way = WAY_BITS'(w);
                hit_val = rd_val[w];
            end
            if (!live && !free) begin
                free     = 1'b1;
                free_way = WAY_BITS'(w);
            end
        end
    end

    // Table array: sweep clear, RESP write, RD snapshot
    always_ff @(posedge clk) begin
        if (state == S_INIT) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                vld_mem[w][sweep_idx] <= 1'b0;
            end
        end else if ((state == S_RESP) && wr_en) begin
            vld_mem[wr_way][idx_q] <= wr_vld;
            key_mem[wr_way][idx_q] <= key_q;
            val_mem[wr_way][idx_q] <= val_q;
            ts_mem[wr_way][idx_q]  <= wr_ts;
        end
        if (state == S_RD) begin
            for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                rd_vld[w] <= vld_mem[w][idx_q];
                rd_key[w] <= key_mem[w][idx_q];
                rd_val[w] <= val_mem[w][idx_q];
                rd_ts[w]  <= ts_mem[w][idx_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_INIT;
            sweep_idx <= '0;
            ts_now    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_flag  <= '0;
            out_value <= '0;
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            op_q      <= '0;
            key_q     <= '0;
            val_q     <= '0;
            idx_q     <= '0;
            wr_en     <= 1'b0;
            wr_vld    <= 1'b0;
            wr_way    <= '0;
            wr_ts     <= '0;
        end else begin
            if (ts_tick) begin
                ts_now <= ts_now + TS_BITS'(1);
            end
            case (state)
                S_INIT: begin
                    sweep_idx <= sweep_idx + IDX_BITS'(1);
                    if (&sweep_idx) begin
                        state    <= S_IDLE;
                        in_ready <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (in_valid) begin
                        op_q     <= in_op;
                        key_q    <= in_key;
                        val_q    <= in_value;
                        idx_q    <= hash_idx(in_key);
                        in_ready <= 1'b0;
                        state    <= S_RD;
                    end
                end
                S_RD: begin
                    state <= S_CMP;
                end
                S_CMP: begin
                    out_valid <= 1'b1;
                    out_value <= '0;
                    wr_en     <= 1'b0;
                    wr_vld    <= 1'b1;
                    wr_ts     <= ts_now;
                    wr_way    <= hit ? hit_way : free_way;
                    case (op_q)
                        OP_LOOKUP: begin
                            if (hit) begin
                                out_flag  <= RC_HIT;
                                out_value <= hit_val;
                                if (hit_cnt != '1) hit_cnt <= hit_cnt + 32'd1;
                            end else begin
                                out_flag <= RC_MISS;
                                if (miss_cnt != '1) miss_cnt <= miss_cnt + 32'd1;
                            end
                        end
                        OP_INSERT: begin
                            if (hit) begin
                                out_flag <= RC_UPDATED;
                                wr_en    <= 1'b1;
                            end else if (free) begin
                                out_flag <= RC_INSERTED;
                                wr_en    <= 1'b1;
                            end else begin
                                out_flag <= RC_FULL;
                            end
                        end
                        OP_DELETE: begin
                            if (hit) begin
                                out_flag <= RC_DELETED;
                                wr_en    <= 1'b1;
                                wr_vld   <= 1'b0;
                            end else begin
                                out_flag <= RC_MISS;
                            end
                        end
                        default: begin
                            out_flag <= RC_BADOP;
                        end
                    endcase
                    state <= S_RESP;
                end
                S_RESP: begin
                    out_valid <= 1'b0;
                    out_flag  <= '0;
                    out_value <= '0;
                    wr_en     <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_db_engine.sv
module tb_db_engine;

    localparam logic [3:0] OP_LOOKUP = 4'd1;
    localparam logic [3:0] OP_INSERT = 4'd2;
    localparam logic [3:0] OP_DELETE = 4'd3;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [95:0] in_key;
    logic [31:0] in_value;
    logic        out_valid;
    logic [3:0]  out_flag;
    logic [31:0] out_value;
    logic        ts_tick;
    logic [15:0] cfg_timeout;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int tests_run;
    int tests_failed;
    int exp_hit;
    int exp_miss;
    int lo_cnt;

    db_engine #(
        .KEY_SIZE (96),
        .VAL_SIZE (32),
        .FLAG_SIZE(4),
        .IDX_BITS (4),
        .NUM_WAYS (2),
        .TS_BITS  (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_key     (in_key),
        .in_value   (in_value),
        .out_valid  (out_valid),
        .out_flag   (out_flag),
        .out_value  (out_value),
        .ts_tick    (ts_tick),
        .cfg_timeout(cfg_timeout),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where out_valid is seen.
    task automatic do_op(input logic [3:0] op, input logic [95:0] key, input logic [31:0] val,
                         output logic [3:0] flag, output logic [31:0] value, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("ready_wait", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_key   = key;
        in_value = val;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_op    = 4'hF;
        in_key   = '1;
        in_value = '1;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        flag  = out_flag;
        value = out_value;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [95:0] key,
                          input logic [31:0] val, input logic [3:0] exp_flag, input logic [31:0] exp_val);
        logic [3:0]  flag;
        logic [31:0] value;
        int          lat;
        do_op(op, key, val, flag, value, lat);
        check({tag, "_flag"}, 64'(flag), 64'(exp_flag));
        check({tag, "_value"}, 64'(value), 64'(exp_val));
        check({tag, "_lat"}, 64'(lat), 64'd3);
    endtask

    task automatic tick();
        ts_tick = 1'b1;
        @(negedge clk);
        ts_tick = 1'b0;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hit_cnt"}, 64'(hit_cnt), 64'(exp_hit));
        check({tag, "_miss_cnt"}, 64'(miss_cnt), 64'(exp_miss));
    endtask

    // Release reset at a negedge and verify the 16-cycle INIT sweep.
    task automatic release_and_sweep(input string tag);
        rst_n = 1'b1;
        lo_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (!in_ready) lo_cnt++;
        end
        check({tag, "_ready_low"}, 64'(lo_cnt), 64'd15);
        @(negedge clk);
        check({tag, "_ready_high"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_hit      = 0;
        exp_miss     = 0;
        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_op        = '0;
        in_key       = '0;
        in_value     = '0;
        ts_tick      = 1'b0;
        cfg_timeout  = '0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_flag", 64'(out_flag), 64'd0);
        check("rst_out_value", 64'(out_value), 64'd0);
        check_counters("rst");
        release_and_sweep("init");

        // Empty table
        run_op("lk_empty", OP_LOOKUP, 96'h1, 32'h0, 4'd2, 32'h0);
        exp_miss++;
        check_counters("lk_empty");

        // Insert then lookup (key 0xA5 -> idx 0xF)
        run_op("ins_a5", OP_INSERT, 96'hA5, 32'hDEADBEEF, 4'd3, 32'h0);
        run_op("lk_a5", OP_LOOKUP, 96'hA5, 32'h0, 4'd1, 32'hDEADBEEF);
        exp_hit++;
        check_counters("lk_a5");

        // Keys 0x3, 0x30, 0x300 all fold to idx 3
        run_op("ins_c0", OP_INSERT, 96'h3, 32'h11, 4'd3, 32'h0);
        run_op("ins_c1", OP_INSERT, 96'h30, 32'h22, 4'd3, 32'h0);
        run_op("ins_full", OP_INSERT, 96'h300, 32'h33, 4'd5, 32'h0);
        run_op("upd_c0", OP_INSERT, 96'h3, 32'h2, 4'd4, 32'h0);
        run_op("lk_c0", OP_LOOKUP, 96'h3, 32'h0, 4'd1, 32'h2);
        exp_hit++;
        run_op("lk_full", OP_LOOKUP, 96'h300, 32'h0, 4'd2, 32'h0);
        exp_miss++;
        check_counters("collide");

        // Delete
        run_op("del_a5", OP_DELETE, 96'hA5, 32'h0, 4'd6, 32'h0);
        run_op("lk_del", OP_LOOKUP, 96'hA5, 32'h0, 4'd2, 32'h0);
        exp_miss++;
        run_op("del_absent", OP_DELETE, 96'hA5, 32'h0, 4'd2, 32'h0);

        // Bad op leaves the table alone
        run_op("badop", 4'd9, 96'h30, 32'h99, 4'd7, 32'h0);
        run_op("lk_after_bad", OP_LOOKUP, 96'h30, 32'h0, 4'd1, 32'h22);
        exp_hit++;
        check_counters("badop");

        // Expiry with cfg_timeout=3 (ts_now starts at 0)
        cfg_timeout = 16'd3;
        run_op("ins_7", OP_INSERT, 96'h7, 32'h77, 4'd3, 32'h0);
        tick();
        tick();
        tick();
        run_op("lk_expired", OP_LOOKUP, 96'h7, 32'h0, 4'd2, 32'h0);
        exp_miss++;
        run_op("ins_reuse", OP_INSERT, 96'h70, 32'h70, 4'd3, 32'h0);
        tick();
        tick();
        run_op("lk_age2", OP_LOOKUP, 96'h70, 32'h0, 4'd1, 32'h70);
        exp_hit++;
        run_op("ins_7b", OP_INSERT, 96'h700, 32'h7B, 4'd3, 32'h0);
        run_op("ins_7full", OP_INSERT, 96'h7000, 32'h7C, 4'd5, 32'h0);

        // Same sequence with expiry disabled
        cfg_timeout = 16'd0;
        run_op("ins_8", OP_INSERT, 96'h8, 32'h88, 4'd3, 32'h0);
        tick();
        tick();
        tick();
        run_op("lk_noexp", OP_LOOKUP, 96'h8, 32'h0, 4'd1, 32'h88);
        exp_hit++;
        check_counters("expiry");

        // Reset during CMP of an INSERT
        while (!in_ready) @(negedge clk);
        in_valid = 1'b1;
        in_op    = OP_INSERT;
        in_key   = 96'hB;
        in_value = 32'hBB;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        lo_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) lo_cnt++;
        end
        check("abort_no_resp", 64'(lo_cnt), 64'd0);
        check("abort_ready", 64'(in_ready), 64'd0);
        exp_hit  = 0;
        exp_miss = 0;
        check_counters("abort");
        release_and_sweep("resweep");
        run_op("lk_aborted", OP_LOOKUP, 96'hB, 32'h0, 4'd2, 32'h0);
        exp_miss++;
        run_op("lk_swept", OP_LOOKUP, 96'h8, 32'h0, 4'd2, 32'h0);
        exp_miss++;
        check_counters("resweep");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
